// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 8-bit core.
// Takes one ALU operation per accepted start and produces a write-back
// request for the RegisterFile. MUL runs as an 8-step shift-add; every
// other op completes in a single EXEC cycle. Holds the core's Z/C flags.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start, op, rd       request, opcode, destination register
//   src_a, src_b        operands (from RegisterFile read ports)
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle completion pulse (the WB cycle)
//   wb_en/addr/data     write-back request to the RegisterFile
//   flag_z, flag_c      zero and carry/borrow flags
//
// Handshake: start is sampled only while busy=0 (IDLE). When start=1 at
// an edge, op/rd/src_a/src_b are latched at that same edge and the
// request is accepted; start in any busy state is ignored, not queued.
module exec_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  // Multiplier datapath: 16-bit accumulator and shifted multiplicand.
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     shl_wide;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  assign busy = (state != IDLE);

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  // Bit DATA_W of the extended difference is the borrow (a < b).
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  // One extra bit above the result catches the last bit shifted out;
  // a zero shift leaves it 0.
  assign shl_wide = {1'b0, a_q} << b_q[SH_W-1:0];
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
      OP_SUB,
      OP_CMP: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = shl_wide[DATA_W-1:0];
        alu_c   = shl_wide[DATA_W];
      end
      // MUL: only meaningful on the final iteration, when acc_next holds
      // the complete product.
      OP_MUL: begin
        alu_res = acc_next[DATA_W-1:0];
        alu_c   = |acc_next[2*DATA_W-1:DATA_W];
      end
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            rd_q <= rd;
            a_q  <= src_a;
            b_q  <= src_b;
            if (op == OP_MUL) begin
              acc    <= '0;
              cnt    <= '0;
              mcand  <= {{DATA_W{1'b0}}, src_a};
              mplier <= src_b;
              state  <= MUL;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          // CMP only sets flags; the write-back data register keeps its value.
          if (op_q != OP_CMP) wb_data <= alu_res;
          wb_addr <= rd_q;
          flag_z  <= (alu_res == '0);
          flag_c  <= alu_c;
          done    <= 1'b1;
          // R0 is hardwired zero, so it is never written.
          wb_en   <= (op_q != OP_CMP) && (rd_q != '0);
          state   <= WB;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            wb_data <= alu_res;
            wb_addr <= rd_q;
            flag_z  <= (alu_res == '0);
            flag_c  <= alu_c;
            done    <= 1'b1;
            wb_en   <= (rd_q != '0);
            state   <= WB;
          end
        end
        WB: begin
          done  <= 1'b0;
          wb_en <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed steps covering each operation and the
// boundary cases, then randomized ops compared against an arithmetic model.
module tb_exec_unit;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [2:0] rd;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic       busy;
  logic       done;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flag_z;
  logic       flag_c;

  always #5 clk = ~clk;

  exec_unit #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  logic [2:0] exp_addr = 3'd0;
  logic       exp_z = 1'b0;
  logic       exp_c = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic void model(input logic [2:0] o, input logic [7:0] a,
                                input logic [7:0] b, output logic [7:0] r,
                                output logic c);
    int full;
    int amt;
    full = 0;
    c    = 1'b0;
    case (o)
      3'd0: begin full = int'(a) + int'(b); c = (full > 255); end
      3'd1, 3'd7: begin full = (int'(a) - int'(b)) & 255; c = (a < b); end
      3'd2: full = int'(a & b);
      3'd3: full = int'(a | b);
      3'd4: full = int'(a ^ b);
      3'd5: begin
        amt  = int'(b % 8);
        full = int'(a) << amt;
        c    = (amt != 0) && (((int'(a) >> (8 - amt)) & 1) == 1);
      end
      default: begin full = int'(a) * int'(b); c = (full > 255); end
    endcase
    r = full[7:0];
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] o, input logic [2:0] r,
                        input logic [7:0] a, input logic [7:0] b, input bit hold);
    logic [7:0] res;
    logic       c;
    int         cyc;
    int         lat;
    bit         got;
    model(o, a, b, res, c);
    lat   = (o == 3'd6) ? 8 : 1;
    exp_z = (res == 8'h00);
    exp_c = c;
    if (o != 3'd7) begin
      exp_data = res;
      exp_addr = r;
    end
    exp_q.push_back(exp_data);

    @(negedge clk);
    start = 1'b1; op = o; rd = r; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    // Scramble the request inputs; the latched copies must be used.
    op    = 3'($urandom_range(7, 0));
    rd    = 3'($urandom_range(7, 0));
    src_a = 8'($urandom_range(255, 0));
    src_b = 8'($urandom_range(255, 0));

    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else check("busy_before_done", 16'(busy), 16'(1));
    end
    check("done_seen", 16'(got), 16'(1));
    if (got) begin
      check("latency", 16'(cyc - 1), 16'(lat));
      check("busy_in_wb", 16'(busy), 16'(1));
      check("wb_en", 16'(wb_en), 16'((o != 3'd7) && (r != 3'd0)));
      check("wb_data", 16'(wb_data), 16'(exp_q.pop_front()));
      if (o != 3'd7) check("wb_addr", 16'(wb_addr), 16'(exp_addr));
      check("flag_z", 16'(flag_z), 16'(exp_z));
      check("flag_c", 16'(flag_c), 16'(exp_c));
    end
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 16'(done), 16'(0));
    check("wb_en_one_cycle", 16'(wb_en), 16'(0));
    check("busy_after", 16'(busy), 16'(0));
    check("wb_data_hold", 16'(wb_data), 16'(exp_data));
    check("flag_z_hold", 16'(flag_z), 16'(exp_z));
    check("flag_c_hold", 16'(flag_c), 16'(exp_c));
    if (hold) begin
      @(negedge clk);
      check("no_second_start", 16'(busy), 16'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 16'(busy), 16'(0));
    check({tag, "_done"}, 16'(done), 16'(0));
    check({tag, "_wb_en"}, 16'(wb_en), 16'(0));
    check({tag, "_wb_addr"}, 16'(wb_addr), 16'(0));
    check({tag, "_wb_data"}, 16'(wb_data), 16'(0));
    check({tag, "_flag_z"}, 16'(flag_z), 16'(0));
    check({tag, "_flag_c"}, 16'(flag_c), 16'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = 3'd0; rd = 3'd0; src_a = 8'h00; src_b = 8'h00;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 3'd3, 8'hF0, 8'h20, 1'b0);   // ADD with carry
    run_op(3'd1, 3'd2, 8'h05, 8'h05, 1'b0);   // SUB to zero
    run_op(3'd7, 3'd6, 8'h03, 8'h07, 1'b0);   // CMP with borrow
    run_op(3'd6, 3'd5, 8'h0F, 8'h11, 1'b0);   // MUL = FFh
    run_op(3'd6, 3'd6, 8'h20, 8'h10, 1'b0);   // MUL overflow, low byte 0
    run_op(3'd0, 3'd0, 8'h01, 8'h01, 1'b0);   // rd=0: no write-back
    run_op(3'd5, 3'd4, 8'h81, 8'h01, 1'b0);   // SHL carry out
    run_op(3'd5, 3'd4, 8'h81, 8'h08, 1'b0);   // SHL amount 0 (b[7:3] ignored)
    run_op(3'd6, 3'd7, 8'h03, 8'h04, 1'b1);   // MUL with start held high

    // Reset four cycles into a MUL: outputs clear without a clock edge.
    @(negedge clk);
    start = 1'b1; op = 3'd6; rd = 3'd2; src_a = 8'hFF; src_b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_op_reset");
    exp_data = 8'h00; exp_addr = 3'd0; exp_z = 1'b0; exp_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || wb_en) saw_done = 1'b1;
    end
    check("aborted_no_done", 16'(saw_done), 16'(0));
    check_all_zero("after_abort");

    run_op(3'd0, 3'd1, 8'h01, 8'h02, 1'b0);   // normal op after reset

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
             8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
             bit'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage of the 8-bit core; sits directly downstream of RegisterFile read ports (out1_r/out2_r feed src_a/src_b).
- Executes one ALU operation per start and produces a write-back request (wb_en/wb_addr/wb_data) that drives the RegisterFile write port.
- Most ops take one cycle. MUL is iterative shift-add over 8 cycles.
- Holds the Z/C flag register for the core.

Parameters:
- DATA_W, 8, operand/result width (only 8 is verified).
- ADDR_W, 3, destination register address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 CMP.
- rd  in  ADDR_W  destination register.
- src_a  in  DATA_W  operand A.
- src_b  in  DATA_W  operand B.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- wb_en  out  1  one-cycle write-back strobe, to RegisterFile write_en.
- wb_addr  out  ADDR_W  write-back address, to RegisterFile addr_wr.
- wb_data  out  DATA_W  write-back data, to RegisterFile data_wr.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, wb_en, wb_addr, wb_data, flag_z, flag_c all 0; multiplier datapath cleared.
- Reset mid-operation aborts the op: no done, no wb_en, flags unchanged from their reset value 0.
- FSM states: IDLE, EXEC, MUL, WB.
- IDLE + start=1 at edge k:
  - Latch op, rd, src_a, src_b.
  - op=MUL → MUL with acc=0, cnt=0. Any other op → EXEC.
- IDLE + start=0: stay in IDLE.
- start is ignored in EXEC, MUL and WB. It is not queued.
- Latched operands are used throughout; changes on src_a/src_b/op/rd after edge k have no effect.
- EXEC, edge k+1:
  - Compute the result and register it into wb_data, wb_addr=rd.
  - Update flags, go to WB.
- MUL (shift-add), each edge:
  - If mplier[0]=1, acc += mcand (16-bit acc).
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - On the 8th iteration (edge k+8), register the result and flags, go to WB.
- WB:
  - done=1 for exactly one cycle.
  - wb_en=1 for the same cycle unless op=CMP or rd=0.
  - Next edge → IDLE: done=0, wb_en=0, busy=0.
- Latency (start edge k):
  - Single-cycle ops: done high from edge k+1 to edge k+2.
  - MUL: done high from edge k+8 to edge k+9.
  - Earliest next accepted start: edge k+3 (single-cycle) / edge k+10 (MUL).
- wb_data and wb_addr hold their last values after done; only wb_en pulses.
- Results (8-bit, truncated):
  - ADD: a+b; C = carry-out of bit 7.
  - SUB: a−b mod 256; C = 1 iff a<b (borrow).
  - AND / OR / XOR: bitwise; C=0.
  - SHL: a << b[2:0]; C = last bit shifted out; C=0 if shift amount is 0. b[7:3] is ignored.
  - MUL: low byte of a*b; C = 1 iff high byte ≠ 0.
  - CMP: flags computed as SUB; wb_data not updated; wb_en never asserted.
- flag_z = (8-bit result == 0).
- Flags update only at the edge entering WB and hold otherwise.
- rd=0: the result is still computed, flags still update and done still pulses, but wb_en stays 0 (R0 is hardwired zero).
- busy=1 exactly while the state is not IDLE, including the WB cycle.

Test Plan:
- ADD: start, op=000, rd=3, a=F0h, b=20h → one cycle later done=1 and wb_en=1 for 1 cycle, wb_addr=3, wb_data=10h, C=1, Z=0.
- SUB then CMP:
  - SUB rd=2, a=05h, b=05h → wb_data=00h, Z=1, C=0.
  - Then CMP a=03h, b=07h → done pulse, wb_en stays 0, wb_data stays 00h, Z=0, C=1.
- MUL:
  - a=0Fh, b=11h, rd=5 → done exactly 8 edges after the start edge, wb_data=FFh, C=0, busy high for 9 cycles.
  - a=20h, b=10h → wb_data=00h, Z=1, C=1.
- rd=0 and SHL:
  - ADD rd=0, a=01h, b=01h → done pulses, wb_en never 1, Z=0, C=0.
  - SHL rd=4, a=81h, b=01h → wb_data=02h, C=1.
- Ignored inputs: start held high and src_a/src_b changed during a MUL (a=03h, b=04h) → result still 0Ch, second start not executed, next op accepted only after return to IDLE.
- Reset mid-op: assert rst 4 cycles into MUL → all outputs 0 immediately (no clock edge needed), done never pulses; after release, ADD 01h+02h rd=1 → wb_data=03h normally.
